ref_fetch_server: RTL and testbench



---
 rtl/ref_fetch_server.sv | 170 +++++++++++++++++
 tb/tb_ref_fetch_server.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_fetch_server.sv
// Prefetches reference-frame words over a burst read bus into a circular window and serves them
// to the reference buffer by address. Define REF_FETCH_STATS_EN to add the stall_cycles counter.
module ref_fetch_server #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ref_mem_addr,
  output logic [63:0] ref_in,
  output logic        ref_en,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic [7:0]  bus_req_len,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_data,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef REF_FETCH_STATS_EN
  ,output logic [31:0] stall_cycles
`endif
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_ptr_q, fetch_ptr_d;
  logic [31:0]      recv_ptr_q, recv_ptr_d;
  logic             req_valid_q, req_valid_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [7:0]       req_len_q, req_len_d;
  logic             err_q, err_d;
  logic [31:0]      prev_addr_q;
  logic             prev_en_q;
  logic [63:0]      win_q [DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      remain_words, len_words, ahead_words;
  logic             window_ok;

  // A burst is only issued if its last word still lands inside the window above ref_mem_addr.
  always_comb begin
    remain_words = (FRAME_BYTES - fetch_ptr_q) >> 3;
    len_words    = (remain_words < 32'(BURST_LEN)) ? remain_words : 32'(BURST_LEN);
    ahead_words  = (fetch_ptr_q - ref_mem_addr) >> 3;
    window_ok    = (ahead_words + len_words) <= 32'(DEPTH);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    recv_ptr_d  = recv_ptr_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_idx      = recv_ptr_q[IDX_W+2:3];

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (req_valid_q) begin
          if (bus_req_ready) begin
            req_valid_d = 1'b0;
            fetch_ptr_d = fetch_ptr_q + (32'(req_len_q) << 3);
          end
        end else if (fetch_ptr_q == FRAME_BYTES) begin
          state_d = S_DRAIN;
        end else if (window_ok) begin
          req_valid_d = 1'b1;
          req_addr_d  = BASE_ADDR + fetch_ptr_q;
          req_len_d   = len_words[7:0];
        end
      end
      S_DRAIN: if (recv_ptr_q == FRAME_BYTES) state_d = S_DONE;
      default: ;
    endcase

    if (state_q != S_IDLE) begin
      if (bus_rsp_valid) begin
        if (recv_ptr_q == fetch_ptr_q) begin
          err_d = 1'b1;
        end else begin
          wr_en      = 1'b1;
          recv_ptr_d = recv_ptr_q + 32'd8;
        end
      end
      // Consumer protocol: aligned, monotonic, one word per enabled cycle.
      if (ref_mem_addr[2:0] != 3'b000) err_d = 1'b1;
      if (ref_mem_addr < prev_addr_q) err_d = 1'b1;
      if (ref_mem_addr > prev_addr_q && (ref_mem_addr - prev_addr_q) > 32'd8) err_d = 1'b1;
      if (ref_mem_addr != prev_addr_q && !prev_en_q) err_d = 1'b1;
    end
  end

  always_comb begin
    ref_en = 1'b0;
    ref_in = '0;
    rd_idx = ref_mem_addr[IDX_W+2:3];
    if (state_q != S_IDLE) begin
      if (ref_mem_addr < recv_ptr_q) begin
        ref_en = 1'b1;
        ref_in = win_q[rd_idx];
      end else if (ref_mem_addr >= FRAME_BYTES && recv_ptr_q == FRAME_BYTES) begin
        ref_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= '0;
      recv_ptr_q  <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      err_q       <= 1'b0;
      prev_addr_q <= '0;
      prev_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      recv_ptr_q  <= recv_ptr_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      err_q       <= err_d;
      prev_addr_q <= ref_mem_addr;
      prev_en_q   <= ref_en;
    end
  end

  // NOTE: the window storage is not reset; only entries below recv_ptr are ever served.
  always_ff @(posedge clk) begin
    if (wr_en) win_q[wr_idx] <= bus_rsp_data;
  end

  assign bus_req_valid = req_valid_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_len   = req_len_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

`ifdef REF_FETCH_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (busy && !ref_en && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ref_fetch_server.sv
// Directed bench for ref_fetch_server: a bus responder with two-cycle latency, an address-driven
// consumer that checks every served word, and a main sequence of directed scenarios.
module tb_ref_fetch_server;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BURST_LEN = 8;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] FRAME     = 32'd200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ref_mem_addr;
  logic [63:0] ref_in;
  logic        ref_en;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b1;
  logic [31:0] bus_req_addr;
  logic [7:0]  bus_req_len;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        busy, done, err;

  ref_fetch_server #(
    .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .BASE_ADDR(BASE), .FRAME_BYTES(FRAME)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .ref_mem_addr(ref_mem_addr),
    .ref_in(ref_in), .ref_en(ref_en),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_len(bus_req_len),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_data(input int i);
    return {32'hCAFE_0000 + 32'(i), 32'h1234_5678 ^ (32'(i) * 32'd7)};
  endfunction

  function automatic logic [63:0] exp_word(input logic [31:0] a);
    if (a >= FRAME) return '0;
    return word_data(int'(a >> 3));
  endfunction

  // Controls owned by the main sequence.
  bit          cons_auto = 0;
  logic [31:0] cons_limit = '0;
  bit          rsp_hold = 0;
  int          set_req = 0;
  logic [31:0] set_val = '0;
  int          inj_req = 0;

  // Logs owned by the bus model and the consumer.
  int          cyc = 0;
  int          hs_count = 0;
  logic [31:0] hs_addr[$];
  logic [7:0]  hs_len[$];
  int          rsp_cyc_log[$];
  int          en_rise_log[$];
  int          n_words = 0;

  // Bus responder: words of a burst start two cycles after the handshake, back to back, in order.
  initial begin
    int idx_q[$];
    int due_q[$];
    int last_due;
    int inj_ack;
    last_due = 0;
    inj_ack = 0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idx_q.delete();
        due_q.delete();
        last_due = 0;
      end else if (bus_req_valid && bus_req_ready) begin
        int d;
        hs_count++;
        hs_addr.push_back(bus_req_addr);
        hs_len.push_back(bus_req_len);
        d = cyc + 2;
        for (int k = 0; k < int'(bus_req_len); k++) begin
          if (d <= last_due) d = last_due + 1;
          idx_q.push_back(int'((bus_req_addr - BASE) >> 3) + k);
          due_q.push_back(d);
          last_due = d;
          d++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      bus_rsp_valid = 1'b0;
      bus_rsp_data  = '0;
      if (inj_ack != inj_req) begin
        inj_ack = inj_req;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (!rsp_hold && idx_q.size() > 0 && due_q[0] <= cyc) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = word_data(idx_q.pop_front());
        void'(due_q.pop_front());
        rsp_cyc_log.push_back(cyc);
      end
    end
  end

  // Consumer: checks every enabled word, then advances by one word if allowed.
  initial begin
    bit seen, was_en;
    int set_ack;
    ref_mem_addr = '0;
    set_ack = 0;
    was_en = 0;
    forever begin
      @(negedge clk);
      seen = (ref_en === 1'b1);
      if (seen) begin
        if (!was_en) en_rise_log.push_back(cyc);
        check("ref_in", ref_in, exp_word(ref_mem_addr));
      end
      was_en = seen;
      @(posedge clk);
      #1;
      if (set_ack != set_req) begin
        set_ack = set_req;
        ref_mem_addr = set_val;
      end else if (cons_auto && seen && ref_mem_addr < cons_limit) begin
        if (ref_mem_addr < FRAME) n_words++;
        ref_mem_addr = ref_mem_addr + 32'd8;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_addr(input logic [31:0] v);
    set_val = v;
    set_req++;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    cons_auto = 0;
    rsp_hold = 0;
    bus_req_ready = 1'b1;
    set_addr('0);
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ref_en"}, ref_en, 0);
    check({tag, " ref_in"}, ref_in, 0);
    check({tag, " req_valid"}, bus_req_valid, 0);
    check({tag, " req_addr"}, bus_req_addr, 0);
    check({tag, " req_len"}, bus_req_len, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    int h0, r0, e0, w0, n;

    // Reset state.
    do_reset();
    check_reset_outputs("reset");

    // Full frame, always-ready bus, streaming consumer running into the tail.
    h0 = hs_count; r0 = rsp_cyc_log.size(); e0 = en_rise_log.size(); w0 = n_words;
    cons_limit = FRAME + 32'd16;
    cons_auto = 1;
    pulse_start();
    check("stream busy", busy, 1);
    wait_done("stream done");
    n = 0;
    while (ref_mem_addr != cons_limit && n < 40) begin
      tick(1);
      n++;
    end
    check("stream words", 32'(n_words - w0), 25);
    check("stream bursts", 32'(hs_count - h0), 4);
    check("burst0 len", hs_len[h0], 8);
    check("burst2 len", hs_len[h0+2], 8);
    check("burst3 len", hs_len[h0+3], 1);
    check("burst3 addr", hs_addr[h0+3], BASE + 32'd192);
    check("first ref_en latency", 32'(en_rise_log[e0] - rsp_cyc_log[r0]), 1);
    check("tail ref_en", ref_en, 1);
    check("tail ref_in", ref_in, 0);
    check("stream busy idle", busy, 0);
    check("stream err", err, 0);

    // Unsolicited response word while nothing is outstanding.
    inj_req++;
    tick(3);
    check("extra rsp err", err, 1);
    tick(4);
    check("extra rsp err sticky", err, 1);
    check("extra rsp done", done, 1);

    // Frozen consumer: the window admits exactly two bursts, a third once addr reaches 64.
    do_reset();
    h0 = hs_count;
    pulse_start();
    tick(30);
    check("frozen bursts", 32'(hs_count - h0), 2);
    check("frozen addr0", hs_addr[h0], BASE);
    check("frozen addr1", hs_addr[h0+1], BASE + 32'd64);
    check("frozen req_valid", bus_req_valid, 0);
    check("frozen ref_en", ref_en, 1);
    cons_limit = 32'd64;
    cons_auto = 1;
    n = 0;
    while (ref_mem_addr != 32'd64 && n < 40) begin
      tick(1);
      n++;
    end
    tick(20);
    check("window bursts", 32'(hs_count - h0), 3);
    check("window addr2", hs_addr[h0+2], BASE + 32'd128);
    check("window len2", hs_len[h0+2], 8);
    check("window req_valid", bus_req_valid, 0);
    check("window err", err, 0);

    // Request held stable while the bus is not ready.
    do_reset();
    h0 = hs_count;
    bus_req_ready = 1'b0;
    cons_limit = FRAME + 32'd16;
    cons_auto = 1;
    pulse_start();
    n = 0;
    while (bus_req_valid !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall valid", bus_req_valid, 1);
      check("stall addr", bus_req_addr, BASE);
      check("stall len", bus_req_len, 8);
      tick(1);
    end
    check("stall no handshake", 32'(hs_count - h0), 0);
    bus_req_ready = 1'b1;
    tick(1);
    check("ready one burst", 32'(hs_count - h0), 1);
    check("ready valid drop", bus_req_valid, 0);
    wait_done("ready done");
    check("ready bursts", 32'(hs_count - h0), 4);
    check("ready err", err, 0);

    // Reset in DRAIN while the last word is still outstanding, then restart.
    do_reset();
    cons_limit = FRAME + 32'd16;
    cons_auto = 1;
    h0 = hs_count;
    pulse_start();
    n = 0;
    while (hs_count - h0 < 4 && n < 400) begin
      tick(1);
      n++;
    end
    rsp_hold = 1;
    tick(3);
    check("drain busy", busy, 1);
    check("drain done", done, 0);
    rst = 1'b1;
    cons_auto = 0;
    set_val = '0;
    set_req++;
    tick(1);
    rst = 1'b0;
    rsp_hold = 0;
    check_reset_outputs("mid-drain rst");
    h0 = hs_count;
    pulse_start();
    n = 0;
    while (hs_count == h0 && n < 10) begin
      tick(1);
      n++;
    end
    check("restart addr", hs_addr[h0], BASE);
    check("restart len", hs_len[h0], 8);
    cons_auto = 1;
    wait_done("restart done");
    check("restart err", err, 0);

    // Consumer jumping two words at once.
    do_reset();
    pulse_start();
    n = 0;
    while (ref_en !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("jump pre err", err, 0);
    set_addr(32'd16);
    tick(1);
    check("jump err", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
